multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Control sequencer for a simple multicycle CPU. It walks each instruction
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB), generating the instruction
// register load, the data-memory request and the phase-gated register-file
// write. It also maintains the program counter and a retired-instruction
// counter. A data-memory access that is never acknowledged within TMO cycles
// stops the machine in HALTED with the error flag set.
//
// Parameters
//   PCW  program counter width
//   TMO  data-memory wait timeout, in cycles spent in MEM without mem_ready
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   start       begin execution at PC 0 (sampled only in IDLE and HALTED)
//   halt        decoded halt instruction (valid in DECODE)
//   branch      decoded conditional branch (valid DECODE .. next FETCH)
//   jump        decoded unconditional jump (valid DECODE .. next FETCH)
//   zero        ALU zero flag (valid in EXEC)
//   target      branch/jump target address (valid in EXEC)
//   mem_read    decoded load
//   mem_write   decoded store
//   reg_write   decoded register-file write request
//   mem_ready   data-memory acknowledge (ignored outside MEM)
//   pc          current instruction address
//   ir_en       instruction register load enable (FETCH only)
//   mem_req     data-memory request (MEM only)
//   rf_we       register-file write enable (WB only, when reg_write is set)
//   busy        executing (FETCH .. WB)
//   done        halted
//   error       a memory timeout stopped the machine
//   inst_count  retired-instruction count, saturating
//   state       FSM state code, for debug
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int PCW = 10,
  parameter int TMO = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           halt,
  input  logic           branch,
  input  logic           jump,
  input  logic           zero,
  input  logic [PCW-1:0] target,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic           reg_write,
  input  logic           mem_ready,
  output logic [PCW-1:0] pc,
  output logic           ir_en,
  output logic           mem_req,
  output logic           rf_we,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [15:0]    inst_count,
  output logic [2:0]     state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  // Wait counter must be able to hold TMO itself.
  localparam int WW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  localparam logic [WW-1:0]  WAIT_LAST = WW'(TMO - 1);
  localparam logic [WW-1:0]  WAIT_ONE  = WW'(1);
  localparam logic [PCW-1:0] PC_ONE    = PCW'(1);
  localparam logic [15:0]    CNT_MAX   = 16'hFFFF;
  localparam logic [15:0]    CNT_ONE   = 16'd1;

  logic [2:0]     state_reg,  state_next;
  logic [PCW-1:0] pc_reg,     pc_next;
  logic [15:0]    count_reg,  count_next;
  logic [WW-1:0]  wait_reg,   wait_next;
  logic           error_reg,  error_next;
  logic           take_reg,   take_next;
  logic [PCW-1:0] target_reg, target_next;

  logic           advance;     // leaving EXEC/MEM/WB for FETCH
  logic           retire;      // one instruction retired this cycle
  logic           take_now;    // branch/jump decision as evaluated in EXEC
  logic           take_eff;
  logic [PCW-1:0] target_eff;

  assign take_now = jump | (branch & zero);

  // Zero and target are only guaranteed during EXEC, so the redirect decision
  // is captured there and reused when the instruction finishes in MEM or WB.
  assign take_eff   = (state_reg == S_EXEC) ? take_now : take_reg;
  assign target_eff = (state_reg == S_EXEC) ? target   : target_reg;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    count_next  = count_reg;
    wait_next   = wait_reg;
    error_next  = error_reg;
    take_next   = take_reg;
    target_next = target_reg;
    advance     = 1'b0;
    retire      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
          count_next = '0;
        end
      end

      S_FETCH: begin
        state_next = S_DECODE;
      end

      S_DECODE: begin
        if (halt) begin
          state_next = S_HALTED;
          retire     = 1'b1;
        end else begin
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        take_next   = take_now;
        target_next = target;
        if (mem_read | mem_write) begin
          state_next = S_MEM;
          wait_next  = '0;
        end else if (reg_write) begin
          state_next = S_WB;
        end else begin
          state_next = S_FETCH;
          advance    = 1'b1;
        end
      end

      S_MEM: begin
        // An acknowledge wins even on the final allowed cycle.
        if (mem_ready) begin
          if (mem_read) begin
            state_next = S_WB;
          end else begin
            state_next = S_FETCH;
            advance    = 1'b1;
          end
        end else if (wait_reg == WAIT_LAST) begin
          state_next = S_HALTED;
          error_next = 1'b1;
          wait_next  = wait_reg + WAIT_ONE;
        end else begin
          wait_next  = wait_reg + WAIT_ONE;
        end
      end

      S_WB: begin
        state_next = S_FETCH;
        advance    = 1'b1;
      end

      S_HALTED: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
          count_next = '0;
          error_next = 1'b0;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (advance) begin
      pc_next = take_eff ? target_eff : (pc_reg + PC_ONE);
      retire  = 1'b1;
    end

    if (retire && (count_reg != CNT_MAX)) begin
      count_next = count_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      pc_reg     <= '0;
      count_reg  <= '0;
      wait_reg   <= '0;
      error_reg  <= 1'b0;
      take_reg   <= 1'b0;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      wait_reg   <= wait_next;
      error_reg  <= error_next;
      take_reg   <= take_next;
      target_reg <= target_next;
    end
  end

  // Phase outputs decode directly from the state register so that reset
  // clears them without waiting for a clock edge.
  assign state      = state_reg;
  assign pc         = pc_reg;
  assign inst_count = count_reg;
  assign error      = error_reg;
  assign ir_en      = (state_reg == S_FETCH);
  assign mem_req    = (state_reg == S_MEM);
  assign rf_we      = (state_reg == S_WB) & reg_write;
  assign done       = (state_reg == S_HALTED);
  assign busy       = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                      (state_reg == S_EXEC)  || (state_reg == S_MEM)    ||
                      (state_reg == S_WB);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Drives programs of instructions (directed and random) into the sequencer.
// For each instruction an instruction-level model predicts the state seen at
// the next FETCH or at the halt, plus the number of mem_req cycles and rf_we
// pulses in between; a monitor compares those predictions as events occur.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

  localparam int PCW   = 10;
  localparam int TMO   = 255;
  localparam int NEVER = 100000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           halt = 1'b0;
  logic           branch = 1'b0;
  logic           jump = 1'b0;
  logic           zero = 1'b0;
  logic [PCW-1:0] target = '0;
  logic           mem_read = 1'b0;
  logic           mem_write = 1'b0;
  logic           reg_write = 1'b0;
  logic           mem_ready = 1'b0;
  logic [PCW-1:0] pc;
  logic           ir_en;
  logic           mem_req;
  logic           rf_we;
  logic           busy;
  logic           done;
  logic           error;
  logic [15:0]    inst_count;
  logic [2:0]     state;

  multicycle_sequencer #(.PCW(PCW), .TMO(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt       (halt),
    .branch     (branch),
    .jump       (jump),
    .zero       (zero),
    .target     (target),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_ready  (mem_ready),
    .pc         (pc),
    .ir_en      (ir_en),
    .mem_req    (mem_req),
    .rf_we      (rf_we),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .inst_count (inst_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit halt; bit branch; bit jump; bit zero;
    int target; bit rd; bit wr; bit rw; int delay;
  } ins_t;

  typedef struct {
    bit is_halt; int pc; int cnt; bit err; int mem_cycles; int rf_pulses;
  } exp_t;

  exp_t sb[$];
  ins_t dir_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pc_m = 0;
  int   cnt_m = 0;
  bit   monitor_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input bit h, input bit br, input bit jp, input bit z,
                              input int tgt, input bit rd, input bit wr, input bit rw,
                              input int dly);
    ins_t i;
    i.halt = h; i.branch = br; i.jump = jp; i.zero = z; i.target = tgt;
    i.rd = rd; i.wr = wr; i.rw = rw; i.delay = dly;
    return i;
  endfunction

  function automatic ins_t rand_ins(input bit last);
    ins_t i;
    int   k;
    i.halt   = last || ($urandom_range(0, 11) == 0);
    i.branch = $urandom_range(0, 1);
    i.jump   = ($urandom_range(0, 3) == 0);
    i.zero   = $urandom_range(0, 1);
    i.target = $urandom_range(0, (1 << PCW) - 1);
    k        = $urandom_range(0, 3);
    i.rd     = (k == 1) || (k == 3);
    i.wr     = (k == 2) || (k == 3);
    i.rw     = $urandom_range(0, 1);
    k        = $urandom_range(0, 19);
    i.delay  = (k == 0) ? NEVER : ((k == 1) ? TMO - 1 : $urandom_range(0, 5));
    return i;
  endfunction

  // Instruction-level reference: what the machine looks like once this
  // instruction is finished.
  task automatic model(input ins_t i, output exp_t e);
    e.is_halt = 0; e.err = 0; e.mem_cycles = 0; e.rf_pulses = 0;
    if (i.halt) begin
      e.is_halt = 1;
      if (cnt_m < 16'hFFFF) cnt_m++;
    end else if (i.rd || i.wr) begin
      if (i.delay < TMO) begin
        e.mem_cycles = i.delay + 1;
        e.rf_pulses  = i.rd ? int'(i.rw) : 0;
        pc_m = (i.jump || (i.branch && i.zero)) ? i.target : (pc_m + 1) % (1 << PCW);
        if (cnt_m < 16'hFFFF) cnt_m++;
      end else begin
        e.is_halt    = 1;
        e.err        = 1;
        e.mem_cycles = TMO;
      end
    end else begin
      e.rf_pulses = int'(i.rw);
      pc_m = (i.jump || (i.branch && i.zero)) ? i.target : (pc_m + 1) % (1 << PCW);
      if (cnt_m < 16'hFFFF) cnt_m++;
    end
    e.pc  = pc_m;
    e.cnt = cnt_m;
  endtask

  task automatic apply(input ins_t i);
    halt      = i.halt;
    branch    = i.branch;
    jump      = i.jump;
    zero      = i.zero;
    target    = PCW'(i.target);
    mem_read  = i.rd;
    mem_write = i.wr;
    reg_write = i.rw;
  endtask

  // Start a program and feed instructions at every FETCH until the machine halts.
  task automatic run_prog(input int n);
    ins_t ins;
    exp_t e;
    int   issued = 0;
    int   d = 0;
    int   mseen = 0;
    int   budget = 0;
    @(negedge clk); #1;
    pc_m = 0; cnt_m = 0;
    e.is_halt = 0; e.pc = 0; e.cnt = 0; e.err = 0; e.mem_cycles = 0; e.rf_pulses = 0;
    sb.push_back(e);
    start = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (done && issued > 0) break;
      if (ir_en) begin
        if (dir_q.size() > 0) ins = dir_q.pop_front();
        else                  ins = rand_ins(issued >= n - 1);
        apply(ins);
        model(ins, e);
        sb.push_back(e);
        d = ins.delay; mseen = 0; issued++;
      end
      if (mem_req) begin
        mem_ready = (mseen == d);
        mseen++;
      end else begin
        mem_ready = $urandom_range(0, 1);
      end
      // Start noise while busy must be ignored.
      start = busy ? ($urandom_range(0, 3) == 0) : 1'b0;
      budget++;
      if (budget > 20000) begin
        checks++; errors++;
        $display("FAIL run_budget actual=expired required=halt");
        break;
      end
    end
    start = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  task automatic wait_ir(output bit ok);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (ir_en) begin ok = 1; break; end
    end
  endtask

  // Monitor: pops one expectation at every FETCH and at every entry to HALTED.
  initial begin
    int   mc = 0;
    int   rc = 0;
    bit   done_prev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!monitor_en) begin
        mc = 0; rc = 0; done_prev = done;
      end else begin
        if (ir_en || (done && !done_prev)) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow actual=event required=none pc=%0h", pc);
          end else begin
            e = sb.pop_front();
            check("event_halted", {31'b0, done}, {31'b0, e.is_halt});
            check("pc", {22'b0, pc}, e.pc);
            check("inst_count", {16'b0, inst_count}, e.cnt);
            check("error", {31'b0, error}, {31'b0, e.err});
            check("mem_req_cycles", mc, e.mem_cycles);
            check("rf_we_pulses", rc, e.rf_pulses);
            if (e.is_halt) check("busy_in_halted", {31'b0, busy}, 32'd0);
          end
          mc = 0; rc = 0;
        end
        if (mem_req) mc++;
        if (rf_we)   rc++;
        done_prev = done;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},      {29'b0, state}, 32'd0);
    check({tag, "_pc"},         {22'b0, pc}, 32'd0);
    check({tag, "_inst_count"}, {16'b0, inst_count}, 32'd0);
    check({tag, "_error"},      {31'b0, error}, 32'd0);
    check({tag, "_busy"},       {31'b0, busy}, 32'd0);
    check({tag, "_done"},       {31'b0, done}, 32'd0);
    check({tag, "_ir_en"},      {31'b0, ir_en}, 32'd0);
    check({tag, "_mem_req"},    {31'b0, mem_req}, 32'd0);
    check({tag, "_rf_we"},      {31'b0, rf_we}, 32'd0);
  endtask

  initial begin
    bit ok;
    #3;
    check_reset_outputs("por");
    @(negedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    halt = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_hold_state", {29'b0, state}, 32'd0);
    mem_ready = 1'b0;
    monitor_en = 1'b1;

    // ALU instruction with register write.
    dir_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    dir_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    run_prog(2);

    // Load acknowledged after three wait cycles.
    dir_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 3));
    dir_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    run_prog(2);

    // Taken branch, not-taken branch, jump to top, not-taken wrap to 0.
    dir_q.push_back(mk(0, 1, 0, 1, 'h155, 0, 0, 0, 0));
    dir_q.push_back(mk(0, 1, 0, 0, 'h0AA, 0, 0, 0, 0));
    dir_q.push_back(mk(0, 0, 1, 0, 'h3FF, 0, 0, 1, 0));
    dir_q.push_back(mk(0, 1, 0, 0, 'h011, 0, 0, 0, 0));
    dir_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    run_prog(5);

    // Store never acknowledged: timeout with error, count unchanged.
    dir_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    dir_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, NEVER));
    run_prog(2);

    // Acknowledge on the last allowed cycle completes normally; also clears error.
    dir_q.push_back(mk(0, 0, 1, 0, 'h020, 1, 0, 1, TMO - 1));
    dir_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    dir_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    run_prog(3);

    for (int p = 0; p < 10; p++) run_prog($urandom_range(3, 12));

    @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    monitor_en = 1'b0;

    // Reset in the middle of a memory wait.
    mem_ready = 1'b0;
    @(negedge clk); #1;
    start = 1'b1;
    wait_ir(ok);
    start = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    if (ok) wait_ir(ok);
    apply(mk(0, 0, 1, 0, 'h02A, 0, 0, 0, 0));
    if (ok) wait_ir(ok);
    apply(mk(0, 0, 0, 0, 0, 1, 0, 1, NEVER));
    check("rst_test_fetch_seen", {31'b0, ok}, 32'd1);
    for (int c = 0; c < 10 && !mem_req; c++) begin
      @(negedge clk); #1;
    end
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
    check("pre_rst_pc", {22'b0, pc}, 32'h02A);
    check("pre_rst_inst_count", {16'b0, inst_count}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_mem_rst");
    @(negedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle_state", {29'b0, state}, 32'd0);
    check("post_rst_idle_pc", {22'b0, pc}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
